// File: rtl/gpio_in_capture.sv
// gpio_in_capture: GPIO input receiver.
// The pins are synchronized (2 flops), debounced per bit, and edge-detected.
// Enabled edges latch into sticky write-1-to-clear status bits, which drive a
// single level interrupt.
// Optional feature macro: GPIO_IN_CAPTURE_TIMESTAMP_EN. It adds a free-running
// 16-bit timestamp that records when the first event arrives while all flags
// are clear.
module gpio_in_capture #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpio_in,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] irq_en,
   input  logic             clr_valid,
   input  logic [WIDTH-1:0] clr_mask,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] status,
   output logic             irq
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
   ,
   output logic [15:0]      ts_first,
   output logic             ts_valid
`endif
);

   typedef enum logic {ST_STABLE = 1'b0, ST_QUALIFY = 1'b1} db_state_t;

   // Reject parameter sets the counter cannot represent.
   if (DEBOUNCE_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_cnt
      $error("gpio_in_capture: DEBOUNCE_CYCLES must be < 2**CNT_W");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("gpio_in_capture: WIDTH must be 1..32");
   end

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] evt_c;
   logic [WIDTH-1:0] status_nxt_c;

   // Two-flop synchronizer for the asynchronous pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= gpio_in;
         sync_q    <= sync_meta;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign level = sync_q;
   end else begin : g_debounce
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
         db_state_t        state_q, state_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             lvl_q, lvl_d;

         // Debounce state, counter and accepted level for this bit.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= ST_STABLE;
               cnt_q   <= '0;
               lvl_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               lvl_q   <= lvl_d;
            end
         end

         // Accept a change only after it persists through DEBOUNCE_CYCLES more samples.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            case (state_q)
               ST_STABLE: begin
                  if (sync_q[i] != lvl_q) begin
                     cnt_d   = CNT_W'(1);
                     state_d = ST_QUALIFY;
                  end else begin
                     cnt_d = '0;
                  end
               end
               ST_QUALIFY: begin
                  if (sync_q[i] == lvl_q) begin
                     cnt_d   = '0;
                     state_d = ST_STABLE;
                  end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                     lvl_d   = sync_q[i];
                     cnt_d   = '0;
                     state_d = ST_STABLE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            endcase
         end

         assign level[i] = lvl_q;
      end
   end

   // Edge events and the next sticky status; a new event wins over a clear.
   always_comb begin
      evt_c        = ((level & ~level_q) & rise_en) | ((~level & level_q) & fall_en);
      status_nxt_c = (status & ~(clr_mask & {WIDTH{clr_valid}})) | evt_c;
   end

   // Previous level for edge compare, and the status register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
         status  <= '0;
      end else begin
         level_q <= level;
         status  <= status_nxt_c;
      end
   end

   // Interrupt follows status and the mask without an extra cycle.
   assign irq = |(status & irq_en);

`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
   logic [15:0] ts_cnt;

   // Free-running timestamp; capture it for the first event after all flags clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_cnt   <= '0;
         ts_first <= '0;
         ts_valid <= 1'b0;
      end else begin
         ts_cnt   <= ts_cnt + 16'd1;
         ts_valid <= |status_nxt_c;
         if ((status == '0) && (|evt_c)) begin
            ts_first <= ts_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gpio_in_capture.sv
// Bench for gpio_in_capture: directed scenarios plus random pin activity,
// checked against a sliding-window behavioural model of sync/debounce/edges.
module tb_gpio_in_capture;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] gpio_in = '0;
   logic [W-1:0] rise_en = '0;
   logic [W-1:0] fall_en = '0;
   logic [W-1:0] irq_en = '0;
   logic         clr_valid = 1'b0;
   logic [W-1:0] clr_mask = '0;
   logic [W-1:0] level;
   logic [W-1:0] status;
   logic         irq;
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
   logic [15:0]  ts_first;
   logic         ts_valid;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   logic [W-1:0] m_level, m_level_q, m_status;
   logic [W-1:0] hist[$];
   logic [W-1:0] seen[$];
   logic [15:0]  m_ts, m_ts_first;

   gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .gpio_in(gpio_in), .rise_en(rise_en),
      .fall_en(fall_en), .irq_en(irq_en), .clr_valid(clr_valid),
      .clr_mask(clr_mask), .level(level), .status(status), .irq(irq)
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
      , .ts_first(ts_first), .ts_valid(ts_valid)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish (time %0t)", $time);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_level = '0; m_level_q = '0; m_status = '0;
      m_ts = '0; m_ts_first = '0;
      hist = {};
      seen = {};
      hist.push_back('0);
      hist.push_back('0);
   endtask

   // One clock edge: advance the model from the pre-edge inputs, then settle.
   task automatic tick();
      logic [W-1:0] evt, clr, nl;
      bit           all_diff;
      @(posedge clk);
      evt = ((m_level & ~m_level_q) & rise_en) | ((~m_level & m_level_q) & fall_en);
      clr = clr_valid ? clr_mask : '0;
      if (m_status == '0 && evt != '0) m_ts_first = m_ts;
      m_ts = m_ts + 16'd1;
      nl = m_level;
      if (D == 0) begin
         nl = hist[hist.size()-1];
      end else begin
         // Level flips once the last D+1 synchronized samples all disagree with it.
         seen.push_back(hist[hist.size()-2]);
         while (seen.size() > D + 1) void'(seen.pop_front());
         if (seen.size() == D + 1) begin
            for (int b = 0; b < W; b++) begin
               all_diff = 1'b1;
               foreach (seen[k]) if (seen[k][b] == m_level[b]) all_diff = 1'b0;
               if (all_diff) nl[b] = ~m_level[b];
            end
         end
      end
      m_level_q = m_level;
      m_level   = nl;
      m_status  = (m_status & ~clr) | evt;
      hist.push_back(gpio_in);
      while (hist.size() > 2) void'(hist.pop_front());
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; gpio_in = '1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (level !== '0 || status !== '0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: level=%h status=%h irq=%b, want 00/00/0", level, status, irq);
      end
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
      n_tests++;
      if (ts_first !== 16'h0 || ts_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ts: ts_first=%h ts_valid=%b, want 0000/0", ts_first, ts_valid);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (level !== m_level) begin
            n_fail++;
            $display("FAIL reset_release_level edge %0d: got %h want %h", k, level, m_level);
         end
         if (k == 6 || k == 7) begin
            n_tests++;
            if (level !== ((k == 7) ? 8'hFF : 8'h00)) begin
               n_fail++;
               $display("FAIL reset_release_timing edge %0d: got %h", k, level);
            end
         end
      end
   endtask

   task automatic test_clean_rise();
      gpio_in = '0;
      repeat (10) tick();
      rise_en = 8'h01; irq_en = 8'h01;
      gpio_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (level !== m_level || status !== m_status || irq !== (|(m_status & irq_en))) begin
            n_fail++;
            $display("FAIL clean_rise edge %0d: level=%h status=%h irq=%b want %h/%h/%b",
                     k, level, status, irq, m_level, m_status, |(m_status & irq_en));
         end
      end
      n_tests++;
      if (level[0] !== 1'b1 || status[0] !== 1'b1 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL clean_rise_final: level0=%b status0=%b irq=%b want 1/1/1", level[0], status[0], irq);
      end
   endtask

   task automatic test_w1c();
      clr_valid = 1'b1; clr_mask = 8'h01;
      tick();
      clr_valid = 1'b0; clr_mask = '0;
      n_tests++;
      if (status[0] !== 1'b0 || irq !== 1'b0 || status !== m_status) begin
         n_fail++;
         $display("FAIL w1c_clear: status=%h irq=%b want %h/0", status, irq, m_status);
      end
      clr_valid = 1'b1; clr_mask = 8'h01;
      tick();
      clr_valid = 1'b0; clr_mask = '0;
      n_tests++;
      if (status !== 8'h00) begin
         n_fail++;
         $display("FAIL w1c_already_clear: status=%h want 00", status);
      end
   endtask

   task automatic test_glitch();
      gpio_in[1] = 1'b1;
      repeat (3) tick();
      gpio_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_tests++;
         if (level[1] !== 1'b0 || status[1] !== 1'b0 || irq !== 1'b0 || level !== m_level) begin
            n_fail++;
            $display("FAIL glitch edge %0d: level=%h status=%h irq=%b", k, level, status, irq);
         end
      end
   endtask

   task automatic test_fall_mask();
      fall_en = 8'h04;
      gpio_in[2] = 1'b1;
      repeat (9) tick();
      gpio_in[2] = 1'b0;
      repeat (9) tick();
      n_tests++;
      if (status[2] !== 1'b1 || irq !== 1'b0 || status !== m_status) begin
         n_fail++;
         $display("FAIL fall_masked: status=%h irq=%b want %h/0", status, irq, m_status);
      end
      irq_en = 8'h05;
      #1;
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL fall_unmask_irq: irq=%b want 1", irq);
      end
      fall_en = '0; irq_en = 8'h01;
      clr_valid = 1'b1; clr_mask = '1;
      tick();
      clr_valid = 1'b0; clr_mask = '0;
   endtask

   task automatic test_collision();
      bit hit = 1'b0;
      fall_en = 8'h01;
      gpio_in[0] = 1'b0;
      repeat (9) tick();
      fall_en = '0;
      n_tests++;
      if (status[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_setup: status=%h want bit0 set", status);
      end
      gpio_in[0] = 1'b1;
      for (int k = 0; k < 20 && !hit; k++) begin
         if (m_level[0] && !m_level_q[0]) begin
            clr_valid = 1'b1; clr_mask = 8'h01;
            hit = 1'b1;
         end
         tick();
         clr_valid = 1'b0; clr_mask = '0;
      end
      n_tests++;
      if (!hit || status[0] !== 1'b1 || status !== m_status) begin
         n_fail++;
         $display("FAIL collision_set_wins: hit=%b status=%h want bit0 set", hit, status);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if (k % 60 == 0) begin
            rise_en = W'($urandom); fall_en = W'($urandom); irq_en = W'($urandom);
         end
         if ($urandom_range(5) == 0) gpio_in = gpio_in ^ (W'($urandom) & W'($urandom));
         clr_valid = ($urandom_range(7) == 0);
         clr_mask  = W'($urandom);
         tick();
         n_tests++;
         if (level !== m_level || status !== m_status || irq !== (|(m_status & irq_en))) begin
            n_fail++;
            $display("FAIL random k=%0d: level=%h status=%h irq=%b want %h/%h/%b",
                     k, level, status, irq, m_level, m_status, |(m_status & irq_en));
         end
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
         n_tests++;
         if (ts_first !== m_ts_first || ts_valid !== (m_status != '0)) begin
            n_fail++;
            $display("FAIL random_ts k=%0d: ts_first=%h ts_valid=%b want %h/%b",
                     k, ts_first, ts_valid, m_ts_first, m_status != '0);
         end
`endif
      end
      clr_valid = 1'b0;
      // Asynchronous reset in the middle of a debounce.
      gpio_in = ~m_level;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (level !== '0 || status !== '0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: level=%h status=%h irq=%b want 00/00/0", level, status, irq);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         tick();
         n_tests++;
         if (level !== m_level || status !== m_status) begin
            n_fail++;
            $display("FAIL post_reset k=%0d: level=%h status=%h want %h/%h", k, level, status, m_level, m_status);
         end
      end
   endtask

`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
   task automatic wait_status(input string tag);
      int guard = 0;
      while (m_status == '0 && guard < 20) begin
         tick();
         guard++;
      end
      n_tests++;
      if (m_status == '0 || status !== m_status) begin
         n_fail++;
         $display("FAIL %s_wait: status=%h want %h", tag, status, m_status);
      end
   endtask

   task automatic test_timestamp();
      logic [15:0] t0;
      rst = 1'b0; gpio_in = '0; rise_en = '1; fall_en = '0; irq_en = '0; clr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      while (m_ts != 16'h0123 - 16'd7) tick();
      gpio_in[3] = 1'b1;
      wait_status("ts_first");
      n_tests++;
      if (ts_first !== 16'h0123 || ts_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ts_first_event: ts_first=%h ts_valid=%b want 0123/1", ts_first, ts_valid);
      end
      gpio_in[5] = 1'b1;
      repeat (10) tick();
      n_tests++;
      if (ts_first !== 16'h0123 || status[5] !== 1'b1) begin
         n_fail++;
         $display("FAIL ts_second_event: ts_first=%h status=%h want 0123, bit5 set", ts_first, status);
      end
      clr_valid = 1'b1; clr_mask = '1;
      tick();
      clr_valid = 1'b0;
      n_tests++;
      if (ts_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ts_clear_valid: ts_valid=%b want 0", ts_valid);
      end
      t0 = m_ts;
      gpio_in[6] = 1'b1;
      wait_status("ts_reload");
      n_tests++;
      if (ts_first !== t0 + 16'd7 || ts_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ts_reload: ts_first=%h want %h", ts_first, t0 + 16'd7);
      end
      clr_valid = 1'b1;
      tick();
      clr_valid = 1'b0;
      for (int g = 0; g < 70000 && m_ts != 16'hFFF8; g++) tick();
      gpio_in[7] = 1'b1;
      wait_status("ts_ffff");
      n_tests++;
      if (ts_first !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL ts_ffff: ts_first=%h want FFFF", ts_first);
      end
      clr_valid = 1'b1;
      tick();
      clr_valid = 1'b0;
      t0 = m_ts;
      gpio_in[0] = 1'b1;
      wait_status("ts_wrap");
      n_tests++;
      if (ts_first !== t0 + 16'd7 || ts_first > 16'h0100) begin
         n_fail++;
         $display("FAIL ts_wrap: ts_first=%h want %h", ts_first, t0 + 16'd7);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_rise();
      test_w1c();
      test_glitch();
      test_fall_mask();
      test_collision();
      test_random();
`ifdef GPIO_IN_CAPTURE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
